// File: rtl/sprite_line_evaluator.sv
// Sprite line evaluator: shadow/active attribute tables, per-line hit scan during blanking.
// Optional SPRITE_STATUS_EN adds a registered Avalon read port for shadow entries and status.
module sprite_line_evaluator #(
  parameter int NUM_SPRITES  = 20,
  parameter int MAX_PER_LINE = 4,
  parameter int SPRITE_H     = 64,
  parameter int H_EVAL       = 640,
  parameter int V_TOTAL      = 525
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        avs_write,
  input  logic [4:0]                  avs_address,
  input  logic [23:0]                 avs_writedata,
`ifdef SPRITE_STATUS_EN
  input  logic                        avs_read,
  output logic [23:0]                 avs_readdata,
`endif
  input  logic [9:0]                  VGA_HCOUNT,
  input  logic [9:0]                  VGA_VCOUNT,
  output logic [24*MAX_PER_LINE-1:0]  line_sprites,
  output logic [MAX_PER_LINE-1:0]     line_valid,
  output logic                        line_update,
  output logic                        line_overflow
);

  localparam int IW = $clog2(NUM_SPRITES);
  localparam logic [4:0] COMMIT_ADDR = 5'(NUM_SPRITES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SPRITES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWAP,
    S_SCAN,
    S_PUB
  } state_t;

  state_t                    r_state;
  logic [23:0]               r_shadow [NUM_SPRITES];
  logic [23:0]               r_active [NUM_SPRITES];
  logic                      r_pending;
  logic [9:0]                r_target;
  logic [IW-1:0]             r_idx;
  logic [24*MAX_PER_LINE-1:0] r_work;
  logic [MAX_PER_LINE-1:0]   r_wvalid;
  logic                      r_wovf;

  logic                      w_entry_wr;
  logic                      w_commit;
  logic                      w_trig;
  logic [9:0]                w_target;
  logic [23:0]               w_entry;
  logic [10:0]               w_y;
  logic [10:0]               w_tgt;
  logic                      w_hit;
  logic [MAX_PER_LINE-1:0]   w_first;

  assign w_entry_wr = avs_write && (avs_address < COMMIT_ADDR);
  assign w_commit   = avs_write && (avs_address == COMMIT_ADDR);
  assign w_trig     = (VGA_HCOUNT == 10'(H_EVAL));
  assign w_target   = (VGA_VCOUNT == 10'(V_TOTAL - 1)) ? 10'd0
                                                       : VGA_VCOUNT + 10'd1;

  // 11-bit compare so y+SPRITE_H past the visible area clips, never wraps
  assign w_entry = r_active[r_idx];
  assign w_y     = {2'b00, w_entry[8:0]};
  assign w_tgt   = {1'b0, r_target};
  assign w_hit   = (w_entry[23:19] != 5'd0)
                && (w_tgt >= w_y)
                && (w_tgt < w_y + 11'(SPRITE_H));

  // slots fill contiguously, so the first free slot is the lowest clear bit
  assign w_first = ~r_wvalid & {r_wvalid[MAX_PER_LINE-2:0], 1'b1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) r_shadow[i] <= '0;
    end else if (w_entry_wr) begin
      r_shadow[avs_address[IW-1:0]] <= avs_writedata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_pending     <= 1'b0;
      r_target      <= '0;
      r_idx         <= '0;
      r_work        <= '0;
      r_wvalid      <= '0;
      r_wovf        <= 1'b0;
      line_sprites  <= '0;
      line_valid    <= '0;
      line_update   <= 1'b0;
      line_overflow <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) r_active[i] <= '0;
    end else begin
      line_update <= 1'b0;
      if (w_commit) r_pending <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_target <= w_target;
            r_idx    <= '0;
            r_work   <= '0;
            r_wvalid <= '0;
            r_wovf   <= 1'b0;
            if (w_target == 10'd0 && r_pending) r_state <= S_SWAP;
            else r_state <= S_SCAN;
          end
        end
        S_SWAP: begin
          for (int i = 0; i < NUM_SPRITES; i++) r_active[i] <= r_shadow[i];
          if (!w_commit) r_pending <= 1'b0;
          r_state <= S_SCAN;
        end
        S_SCAN: begin
          if (w_hit) begin
            if (&r_wvalid) begin
              r_wovf <= 1'b1;
            end else begin
              for (int i = 0; i < MAX_PER_LINE; i++) begin
                if (w_first[i]) begin
                  r_work[24*i +: 24] <= w_entry;
                  r_wvalid[i]        <= 1'b1;
                end
              end
            end
          end
          if (r_idx == LAST_IDX) r_state <= S_PUB;
          else r_idx <= r_idx + 1'b1;
        end
        S_PUB: begin
          line_sprites  <= r_work;
          line_valid    <= r_wvalid;
          line_overflow <= r_wovf;
          line_update   <= 1'b1;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SPRITE_STATUS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      if (avs_address < COMMIT_ADDR)
        avs_readdata <= r_shadow[avs_address[IW-1:0]];
      else if (avs_address == COMMIT_ADDR)
        avs_readdata <= {22'b0, r_pending, line_overflow};
      else
        avs_readdata <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_line_evaluator.sv
// Scoreboard bench for sprite_line_evaluator: directed line triggers,
// expected lists queued at trigger time and checked on each line_update.
module tb_sprite_line_evaluator;

  logic        clk;
  logic        reset_n;
  logic        avs_write;
  logic [4:0]  avs_address;
  logic [23:0] avs_writedata;
  logic [9:0]  VGA_HCOUNT;
  logic [9:0]  VGA_VCOUNT;
  logic [95:0] line_sprites;
  logic [3:0]  line_valid;
  logic        line_update;
  logic        line_overflow;
`ifdef SPRITE_STATUS_EN
  logic        avs_read;
  logic [23:0] avs_readdata;
`endif

  typedef struct {
    logic [95:0] s;
    logic [3:0]  v;
    logic        o;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   updates = 0;

  sprite_line_evaluator dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .avs_write     (avs_write),
    .avs_address   (avs_address),
    .avs_writedata (avs_writedata),
`ifdef SPRITE_STATUS_EN
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
`endif
    .VGA_HCOUNT    (VGA_HCOUNT),
    .VGA_VCOUNT    (VGA_VCOUNT),
    .line_sprites  (line_sprites),
    .line_valid    (line_valid),
    .line_update   (line_update),
    .line_overflow (line_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] d(input int id, input int x, input int y);
    return {5'(id), 10'(x), 9'(y)};
  endfunction

  function automatic logic [95:0] pk(input logic [23:0] a, input logic [23:0] b,
                                     input logic [23:0] c, input logic [23:0] e);
    return {e, c, b, a};
  endfunction

  always @(negedge clk) begin
    if (reset_n && line_update) begin
      exp_t e;
      updates++;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_update got valid=%b ovf=%b exp no update",
                 line_valid, line_overflow);
      end else begin
        e = q.pop_front();
        if ({line_sprites, line_valid, line_overflow} !== {e.s, e.v, e.o}) begin
          fails++;
          $display("FAIL line_list got s=%h v=%b o=%b exp s=%h v=%b o=%b",
                   line_sprites, line_valid, line_overflow, e.s, e.v, e.o);
        end
      end
    end
  end

  task automatic wr(input int addr, input logic [23:0] data);
    avs_write     = 1'b1;
    avs_address   = 5'(addr);
    avs_writedata = data;
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  // sw: 0 none, 1 shadow write entry1 in swap cycle, 2 COMMIT in swap cycle
  task automatic line(input int vc, input logic [95:0] s, input logic [3:0] v,
                      input logic o, input int sw);
    exp_t e;
    e.s = s; e.v = v; e.o = o;
    q.push_back(e);
    VGA_VCOUNT = 10'(vc);
    VGA_HCOUNT = 10'd640;
    @(posedge clk); #1;
    VGA_HCOUNT = 10'd641;
    if (sw == 1) wr(1, d(8, 0, 300));
    if (sw == 2) wr(20, 24'h0);
    repeat (30) @(posedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL timeout got pending=%0d exp 0 (vcount %0d)", q.size(), vc);
      q.delete();
    end
  endtask

`ifdef SPRITE_STATUS_EN
  task automatic rd(input int addr, input logic [23:0] ex);
    avs_read    = 1'b1;
    avs_address = 5'(addr);
    @(posedge clk); #1;
    avs_read = 1'b0;
    tests++;
    if (avs_readdata !== ex) begin
      fails++;
      $display("FAIL read%0d got %h exp %h", addr, avs_readdata, ex);
    end
  endtask
`endif

  logic [95:0] z;
  logic [23:0] e0, e1, e2, e3, e4, e5;
  int          ups;

  initial begin
    z = '0;
    reset_n = 1'b0;
    avs_write = 1'b0;
    avs_address = '0;
    avs_writedata = '0;
    VGA_HCOUNT = 10'd0;
    VGA_VCOUNT = 10'd0;
`ifdef SPRITE_STATUS_EN
    avs_read = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({line_sprites, line_valid, line_update, line_overflow} !== '0) begin
      fails++;
      $display("FAIL reset_state got %h exp 0", line_sprites);
    end
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    line(524, z, 4'b0000, 1'b0, 0);
    line(9,   z, 4'b0000, 1'b0, 0);
    line(49,  z, 4'b0000, 1'b0, 0);

    wr(3, d(1, 100, 10));
    wr(20, 24'h0);
    line(524, z, 4'b0000, 1'b0, 0);
    line(9,  {72'h0, d(1, 100, 10)}, 4'b0001, 1'b0, 0);
    line(72, {72'h0, d(1, 100, 10)}, 4'b0001, 1'b0, 0);
    line(8,  z, 4'b0000, 1'b0, 0);
    line(73, z, 4'b0000, 1'b0, 0);
`ifdef SPRITE_STATUS_EN
    rd(3, 24'h08C80A);
    rd(20, 24'h0);
    rd(25, 24'h0);
`endif

    e0 = d(1, 0, 50);  e1 = d(2, 20, 50); e2 = d(3, 40, 50);
    e3 = d(4, 60, 50); e4 = d(5, 80, 50); e5 = d(6, 100, 50);
    for (int i = 0; i < 6; i++) wr(i, d(i + 1, i * 20, 50));
    wr(20, 24'h0);
    line(524, z, 4'b0000, 1'b0, 0);
    line(49,  pk(e0, e1, e2, e3), 4'b1111, 1'b1, 0);
`ifdef SPRITE_STATUS_EN
    rd(20, 24'h1);
`endif
    line(112, pk(e0, e1, e2, e3), 4'b1111, 1'b1, 0);
    line(113, z, 4'b0000, 1'b0, 0);
    line(9,   z, 4'b0000, 1'b0, 0);

    wr(0, d(7, 0, 200));
    line(524, z, 4'b0000, 1'b0, 0);
    line(49,  pk(e0, e1, e2, e3), 4'b1111, 1'b1, 0);
    line(524, z, 4'b0000, 1'b0, 0);
    line(49,  pk(e0, e1, e2, e3), 4'b1111, 1'b1, 0);

    wr(20, 24'h0);
    line(524, z, 4'b0000, 1'b0, 1);
    line(49,  pk(e1, e2, e3, e4), 4'b1111, 1'b1, 0);
    line(199, {72'h0, d(7, 0, 200)}, 4'b0001, 1'b0, 0);

    wr(20, 24'h0);
    line(524, z, 4'b0000, 1'b0, 2);
    line(49,  pk(e2, e3, e4, e5), 4'b1111, 1'b0, 0);
    line(299, {72'h0, d(8, 0, 300)}, 4'b0001, 1'b0, 0);
    wr(2, d(9, 0, 400));
    line(524, z, 4'b0000, 1'b0, 0);
    line(399, {72'h0, d(9, 0, 400)}, 4'b0001, 1'b0, 0);
    line(49,  pk(e3, e4, e5, 24'h0), 4'b0111, 1'b0, 0);

    VGA_VCOUNT = 10'd49;
    VGA_HCOUNT = 10'd640;
    @(posedge clk); #1;
    VGA_HCOUNT = 10'd641;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    tests++;
    if ({line_sprites, line_valid, line_update, line_overflow} !== '0) begin
      fails++;
      $display("FAIL reset_scan got s=%h v=%b exp 0", line_sprites, line_valid);
    end
    ups = updates;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    tests++;
    if (updates != ups) begin
      fails++;
      $display("FAIL no_update_after_reset got %0d exp %0d", updates, ups);
    end
    line(49,  z, 4'b0000, 1'b0, 0);
    line(524, z, 4'b0000, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
